mfsk_dds_mod: RTL and testbench

//  Parametrised M-ary FSK modulator; successor to the fixed 2-tone clock-divider FSK block.

---
 rtl/mfsk_pkg.sv | 27 ++
 rtl/mfsk_sine_lut.sv | 77 +++++++
 rtl/mfsk_dds_mod.sv | 186 ++++++++++++++++++
 tb/tb_mfsk_dds_mod.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mfsk_pkg.sv
// -----------------------------------------------------------------------------
// mfsk_pkg
// Shared definitions for the M-ary FSK DDS modulator:
//   - state_e    : modulator run state (IDLE, RUN)
//   - M          : tone count for the default symbol width
//   - ftw_of()   : tuning word of a symbol, base + sym*step (mod 2**64;
//                  callers truncate to their own phase width)
// -----------------------------------------------------------------------------
package mfsk_pkg;

    localparam int BITS_PER_SYM_DEF = 2;
    localparam int M                = 2 ** BITS_PER_SYM_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Computed at 64 bits; truncating the result to any narrower width gives
    // the correct modulo-2**W tuning word.
    function automatic logic [63:0] ftw_of(input logic [3:0]  sym,
                                           input logic [63:0] base,
                                           input logic [63:0] step);
        return base + step * 64'(sym);
    endfunction

endpackage

// File: rtl/mfsk_sine_lut.sv
// -----------------------------------------------------------------------------
// mfsk_sine_lut
// Quarter-wave sine ROM with sign/mirror folding. Two register stages:
// ROM read, then sign application. Output forced to 0 while not running.
// Ports:
//   clk      in   1       clock
//   rst_n    in   1       asynchronous active-low reset
//   run_i    in   1       modulator running; low clears both stages
//   phase_i  in   OUT_W   phase (top accumulator bits)
//   sin_o    out  OUT_W   signed sine sample, 2 cycles after phase_i
// -----------------------------------------------------------------------------
module mfsk_sine_lut #(
    parameter int OUT_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_i,
    input  logic [OUT_W-1:0]        phase_i,
    output logic signed [OUT_W-1:0] sin_o
);

    localparam int Q     = 2 ** (OUT_W - 2);
    localparam int MAG_W = OUT_W - 1;
    localparam longint AMP = (longint'(1) << (OUT_W - 1)) - 1;

    // Bhaskara approximation of sin() sampled at the centre of each quarter
    // bin, so that mirroring the index (~idx) is an exact symmetry.
    function automatic logic [MAG_W-1:0] quarter_sine(input int i);
        longint a;
        longint num;
        longint den;
        a   = (2 * longint'(i) + 1) * (4 * longint'(Q) - 2 * longint'(i) - 1);
        num = 4 * a * AMP;
        den = 20 * longint'(Q) * longint'(Q) - a;
        return MAG_W'(num / den);
    endfunction

    logic [MAG_W-1:0] rom [Q];

    for (genvar gi = 0; gi < Q; gi++) begin : g_rom
        assign rom[gi] = quarter_sine(gi);
    end

    logic [1:0]       quad;
    logic [OUT_W-3:0] idx;
    logic [OUT_W-3:0] addr;

    assign quad = phase_i[OUT_W-1 -: 2];
    assign idx  = phase_i[OUT_W-3:0];
    // Quadrants 1 and 3 run the quarter wave backwards.
    assign addr = quad[0] ? ~idx : idx;

    logic [MAG_W-1:0]        mag_q;
    logic                    neg_q;
    logic signed [OUT_W-1:0] sin_q;
    logic signed [OUT_W-1:0] mag_s;

    assign mag_s = $signed({1'b0, mag_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            sin_q <= '0;
        end else begin
            mag_q <= run_i ? rom[addr] : '0;
            neg_q <= run_i & quad[1];
            if (!run_i)
                sin_q <= '0;
            else
                sin_q <= neg_q ? -mag_s : mag_s;
        end
    end

    assign sin_o = sin_q;

endmodule

// File: rtl/mfsk_dds_mod.sv
// -----------------------------------------------------------------------------
// mfsk_dds_mod
// M-ary FSK modulator. Serial bits are packed MSB-first into BITS_PER_SYM-bit
// symbols; each symbol selects tone base + sym*step of a phase-continuous DDS.
// One symbol is held on air (cur) and one buffered (next); a symbol boundary
// occurs every SYM_CYCLES RUN cycles.
// Optional feature macro: MFSK_SINE_LUT_EN adds sin_out fed by mfsk_sine_lut.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                run; low returns to IDLE and flushes all state
//   bit_in/bit_valid      serial bit input, handshake with bit_ready
//   bit_ready             next buffer empty while running
//   ftw_base, ftw_step    tuning words, sampled at symbol boundaries/idle
//   sym_strobe, underrun  1-cycle boundary pulses
//   sq_out, phase_out     accumulator MSB / top OUT_W bits, 1 cycle after acc
//   sin_out               signed sine sample (MFSK_SINE_LUT_EN only)
// -----------------------------------------------------------------------------
module mfsk_dds_mod
    import mfsk_pkg::*;
#(
    parameter int PHASE_W      = 32,
    parameter int OUT_W        = 10,
    parameter int BITS_PER_SYM = BITS_PER_SYM_DEF,
    parameter int SYM_CYCLES   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    input  logic [PHASE_W-1:0]      ftw_base,
    input  logic [PHASE_W-1:0]      ftw_step,
    output logic                    sym_strobe,
    output logic                    underrun,
    output logic                    sq_out,
`ifdef MFSK_SINE_LUT_EN
    output logic [OUT_W-1:0]        phase_out,
    output logic signed [OUT_W-1:0] sin_out
`else
    output logic [OUT_W-1:0]        phase_out
`endif
);

    localparam int CNT_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int BC_W  = $clog2(BITS_PER_SYM) + 1;

    state_e                  state_q, state_d;
    logic [PHASE_W-1:0]      acc_q, acc_d;
    logic [PHASE_W-1:0]      ftw_q, ftw_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BITS_PER_SYM-1:0] collect_q, collect_d;
    logic [BC_W-1:0]         nbits_q, nbits_d;
    logic [BITS_PER_SYM-1:0] next_sym_q, next_sym_d;
    logic                    next_full_q, next_full_d;
    logic [BITS_PER_SYM-1:0] cur_sym_q, cur_sym_d;
    logic                    strobe_q, strobe_d;
    logic                    underrun_q, underrun_d;
    logic                    sq_q, sq_d;
    logic [OUT_W-1:0]        phase_q, phase_d;

    logic                    run;
    logic                    accept;
    logic                    completes;
    logic                    boundary;
    logic [BITS_PER_SYM-1:0] filled_sym;

    // Running means RUN now and staying in RUN; enable low flushes at once.
    assign run        = (state_q == RUN) & enable;
    assign bit_ready  = (state_q == RUN) & ~next_full_q;
    assign accept     = bit_valid & bit_ready;
    assign completes  = accept & (nbits_q == BC_W'(BITS_PER_SYM - 1));
    assign boundary   = run & (cnt_q == CNT_W'(SYM_CYCLES - 1));
    // Shift the incoming bit in below the bits collected so far.
    assign filled_sym = BITS_PER_SYM'({collect_q, bit_in});

    always_comb begin
        state_d     = enable ? RUN : IDLE;
        acc_d       = acc_q;
        ftw_d       = ftw_q;
        cnt_d       = cnt_q;
        collect_d   = collect_q;
        nbits_d     = nbits_q;
        next_sym_d  = next_sym_q;
        next_full_d = next_full_q;
        cur_sym_d   = cur_sym_q;
        strobe_d    = 1'b0;
        underrun_d  = 1'b0;
        sq_d        = acc_q[PHASE_W-1];
        phase_d     = acc_q[PHASE_W-1 -: OUT_W];

        if (!run) begin
            acc_d       = '0;
            cnt_d       = '0;
            collect_d   = '0;
            nbits_d     = '0;
            next_sym_d  = '0;
            next_full_d = 1'b0;
            cur_sym_d   = '0;
            // Idle tone is pre-loaded so the first symbol period carries tone 0.
            ftw_d       = PHASE_W'(ftw_of(4'd0, 64'(ftw_base), 64'(ftw_step)));
            if (!enable) begin
                sq_d    = 1'b0;
                phase_d = '0;
            end
        end else begin
            acc_d = acc_q + ftw_q;
            cnt_d = boundary ? '0 : cnt_q + 1'b1;

            if (accept) begin
                if (completes) begin
                    next_sym_d  = filled_sym;
                    next_full_d = 1'b1;
                    collect_d   = '0;
                    nbits_d     = '0;
                end else begin
                    collect_d = filled_sym;
                    nbits_d   = nbits_q + 1'b1;
                end
            end

            if (boundary) begin
                next_full_d = 1'b0;
                // A symbol completed in this very cycle is taken directly.
                if (next_full_q | completes) begin
                    cur_sym_d = next_full_q ? next_sym_q : filled_sym;
                    strobe_d  = 1'b1;
                end else begin
                    cur_sym_d  = '0;
                    underrun_d = 1'b1;
                end
                ftw_d = PHASE_W'(ftw_of(4'(cur_sym_d), 64'(ftw_base), 64'(ftw_step)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ftw_q       <= '0;
            cnt_q       <= '0;
            collect_q   <= '0;
            nbits_q     <= '0;
            next_sym_q  <= '0;
            next_full_q <= 1'b0;
            cur_sym_q   <= '0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
            sq_q        <= 1'b0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_q       <= ftw_d;
            cnt_q       <= cnt_d;
            collect_q   <= collect_d;
            nbits_q     <= nbits_d;
            next_sym_q  <= next_sym_d;
            next_full_q <= next_full_d;
            cur_sym_q   <= cur_sym_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
            sq_q        <= sq_d;
            phase_q     <= phase_d;
        end
    end

    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;
    assign sq_out     = sq_q;
    assign phase_out  = phase_q;

`ifdef MFSK_SINE_LUT_EN
    mfsk_sine_lut #(
        .OUT_W (OUT_W)
    ) u_sine (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_i   (run),
        .phase_i (phase_q),
        .sin_o   (sin_out)
    );
`endif

endmodule

// File: tb/tb_mfsk_dds_mod.sv
module tb_mfsk_dds_mod;

    localparam int PW = 32;
    localparam int OW = 10;
    localparam int B  = 2;
    localparam int SC = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic [PW-1:0] ftw_base = '0;
    logic [PW-1:0] ftw_step = '0;
    logic          bit_ready;
    logic          sym_strobe;
    logic          underrun;
    logic          sq_out;
    logic [OW-1:0] phase_out;
`ifdef MFSK_SINE_LUT_EN
    logic signed [OW-1:0] sin_out;
`endif

    always #5 clk = ~clk;

    mfsk_dds_mod #(
        .PHASE_W      (PW),
        .OUT_W        (OW),
        .BITS_PER_SYM (B),
        .SYM_CYCLES   (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .ftw_base   (ftw_base),
        .ftw_step   (ftw_step),
        .sym_strobe (sym_strobe),
        .underrun   (underrun),
        .sq_out     (sq_out),
`ifdef MFSK_SINE_LUT_EN
        .phase_out  (phase_out),
        .sin_out    (sin_out)
`else
        .phase_out  (phase_out)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Symbol period = SC running cycles; pending bits kept in a queue, at most
    // one complete symbol waiting; tone word = base + sym*step.
    bit            m_run;
    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_ftw;
    int            m_k;
    int            m_part[$];
    bit            m_has_next;
    int            m_next;
    int            m_cur;
    bit            m_strobe;
    bit            m_underrun;
    bit            m_sq;
    logic [OW-1:0] m_phase;

    task automatic model_clear();
        m_run = 0; m_acc = '0; m_k = 0; m_part.delete();
        m_has_next = 0; m_next = 0; m_cur = 0;
        m_strobe = 0; m_underrun = 0; m_sq = 0; m_phase = '0;
    endtask

    task automatic model_step();
        bit was_ready;
        bit boundary;
        was_ready = m_run && !m_has_next;
        if (!enable) begin
            model_clear();
            m_ftw = ftw_base;
            return;
        end
        if (!m_run) begin
            m_run = 1; m_ftw = ftw_base;
            m_phase = '0; m_sq = 0; m_strobe = 0; m_underrun = 0; m_k = 0;
            return;
        end
        m_phase = m_acc[PW-1 -: OW];
        m_sq    = m_acc[PW-1];
        m_acc   = m_acc + m_ftw;
        if (bit_valid && was_ready) begin
            m_part.push_back(int'(bit_in));
            if (m_part.size() == B) begin
                m_next = 0;
                foreach (m_part[i]) m_next = m_next * 2 + m_part[i];
                m_has_next = 1;
                m_part.delete();
            end
        end
        boundary = ((m_k % SC) == SC - 1);
        m_k++;
        m_strobe = 0; m_underrun = 0;
        if (boundary) begin
            if (m_has_next) begin
                m_cur = m_next; m_has_next = 0; m_strobe = 1;
            end else begin
                m_cur = 0; m_underrun = 1;
            end
            m_ftw = ftw_base + ftw_step * PW'(m_cur);
        end
    endtask

    initial begin
        model_clear();
        m_ftw = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
                m_ftw = '0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("bit_ready",  bit_ready,  m_run && !m_has_next);
        check("sym_strobe", sym_strobe, m_strobe);
        check("underrun",   underrun,   m_underrun);
        check("sq_out",     sq_out,     m_sq);
        check("phase_out",  phase_out,  m_phase);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        // Directed: bits 1,1 -> symbol 3, tone 0x4000_0000.
        rst_n = 1; enable = 1; bit_valid = 1; bit_in = 1;
        ftw_base = 32'h1000_0000; ftw_step = 32'h1000_0000;
        tick(1);                               // after E0
        check("lit_ready_run", bit_ready, 1);
        tick(2);                               // after E2
        check("lit_ready_full", bit_ready, 0);
        bit_valid = 0;
        tick(62);                              // after E64
        check("lit_strobe_e64", sym_strobe, 1);
        check("lit_phase_e64", phase_out, 10'h3C0);
        tick(2);  check("lit_phase_e66", phase_out, 10'h100);
        tick(1);  check("lit_phase_e67", phase_out, 10'h200); check("lit_sq_e67", sq_out, 1);
        tick(1);  check("lit_phase_e68", phase_out, 10'h300); check("lit_sq_e68", sq_out, 1);
        tick(1);  check("lit_phase_e69", phase_out, 10'h000); check("lit_sq_e69", sq_out, 0);
        // Directed: symbol 3 -> symbol 0 mid-phase.
        bit_valid = 1; bit_in = 0;
        tick(2);                               // after E71
        check("lit_ready_e71", bit_ready, 0);
        bit_valid = 0;
        tick(57);                              // after E128
        check("lit_strobe_e128", sym_strobe, 1);
        check("lit_phase_e128", phase_out, 10'h300);
        tick(1);  check("lit_phase_e129", phase_out, 10'h000);
        tick(1);  check("lit_phase_e130", phase_out, 10'h040);
        tick(1);  check("lit_phase_e131", phase_out, 10'h080);
        // Directed: no bits for a whole symbol -> one underrun.
        tick(61);                              // after E192
        check("lit_underrun_e192", underrun, 1);
        tick(1);                               // after E193
        check("lit_underrun_e193", underrun, 0);
        // Directed: bit_valid held high.
        bit_valid = 1; bit_in = 1;
        tick(2);                               // after E195
        check("lit_ready_e195", bit_ready, 0);
        tick(61);                              // after E256
        check("lit_ready_e256", bit_ready, 1);
        check("lit_strobe_e256", sym_strobe, 1);
        tick(2);                               // after E258
        check("lit_ready_e258", bit_ready, 0);
        // Directed: drop enable mid-symbol.
        tick(10);
        enable = 0;
        tick(1);
        check("lit_phase_off", phase_out, 0);
        check("lit_ready_off", bit_ready, 0);
        tick(3);
        enable = 1;
        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (((c / 400) % 2) == 0)
                bit_valid = ($urandom_range(0, 3) != 0);
            else
                bit_valid = ($urandom_range(0, 99) == 0);
            bit_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0)
                enable = 0;
            else if (!enable && $urandom_range(0, 3) == 0)
                enable = 1;
            if ($urandom_range(0, 199) == 0) begin
                ftw_base = $urandom;
                ftw_step = $urandom;
            end
        end
        // Reset mid-run with enable high.
        @(negedge clk);
        enable = 1; bit_valid = 1;
        tick(100);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("lit_rst_ready",    bit_ready, 0);
        check("lit_rst_phase",    phase_out, 0);
        check("lit_rst_sq",       sq_out, 0);
        check("lit_rst_strobe",   sym_strobe, 0);
        check("lit_rst_underrun", underrun, 0);
        tick(2);
        rst_n = 1;
        tick(1);
        check("lit_ready_after_rst", bit_ready, 1);
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
